// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_pkg
// Purpose  : Shared RV32I definitions for the ID/EX issue stage: major
//            opcodes, 5-bit ALU control codes, operand-select encodings and
//            the forwarding-source selector with its priority helper.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00000,
        ALU_SUB  = 5'b10000,
        ALU_AND  = 5'b00010,
        ALU_OR   = 5'b00011,
        ALU_XOR  = 5'b00100,
        ALU_SLT  = 5'b00101,
        ALU_SLL  = 5'b00110,
        ALU_SRL  = 5'b00111,
        ALU_SRA  = 5'b01000,
        ALU_SLTU = 5'b01001
    } alu_op_e;

    typedef enum logic [1:0] {
        A_SEL_RS1  = 2'd0,
        A_SEL_PC   = 2'd1,
        A_SEL_ZERO = 2'd2
    } a_sel_e;

    typedef enum logic [1:0] {
        B_SEL_RS2  = 2'd0,
        B_SEL_IMM  = 2'd1,
        B_SEL_FOUR = 2'd2,
        B_SEL_ZERO = 2'd3
    } b_sel_e;

    typedef enum logic [1:0] {
        FWD_ZERO   = 2'd0,
        FWD_MEM    = 2'd1,
        FWD_WB     = 2'd2,
        FWD_STORED = 2'd3
    } fwd_sel_e;

    // x0 is hard-wired zero; MEM is younger than WB so it wins on a tie.
    function automatic fwd_sel_e fwd_select(
        input logic [4:0] idx,
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd
    );
        if (idx == 5'd0)                    return FWD_ZERO;
        else if (mem_we && (mem_rd == idx)) return FWD_MEM;
        else if (wb_we && (wb_rd == idx))   return FWD_WB;
        else                                return FWD_STORED;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_dec.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_dec
// Purpose  : Purely combinational RV32I decode of opcode/funct3/funct7b5 into
//            the ALU control code, operand-A/B selects, branch and illegal
//            flags.
// Ports    : opcode, funct3, funct7b5, imm_b10 (immediate bit 10, selects
//            SRAI) in; alu_ctrl, a_sel, b_sel, is_branch, illegal out.
// Revision : 1.0 - initial release
// ============================================================================
module alu_ctrl_dec
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       imm_b10,
    output alu_op_e    alu_ctrl,
    output a_sel_e     a_sel,
    output b_sel_e     b_sel,
    output logic       is_branch,
    output logic       illegal
);

    // Shared OP / OP-IMM funct3 table; alt picks SUB on 000 and SRA on 101.
    function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        alu_ctrl  = ALU_ADD;
        a_sel     = A_SEL_RS1;
        b_sel     = B_SEL_IMM;
        is_branch = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OPC_OP: begin
                alu_ctrl = arith_op(funct3, funct7b5);
                b_sel    = B_SEL_RS2;
            end
            OPC_OP_IMM: begin
                // ADDI never subtracts; only the shift-right slot uses imm[10].
                alu_ctrl = arith_op(funct3, (funct3 == 3'b101) ? imm_b10 : 1'b0);
            end
            OPC_LOAD, OPC_STORE: begin
                alu_ctrl = ALU_ADD;
            end
            OPC_BRANCH: begin
                is_branch = 1'b1;
                b_sel     = B_SEL_RS2;
                // funct3[2] separates equality from ordered compares,
                // funct3[1] separates signed from unsigned.
                if (!funct3[2])     alu_ctrl = ALU_SUB;
                else if (funct3[1]) alu_ctrl = ALU_SLTU;
                else                alu_ctrl = ALU_SLT;
            end
            OPC_LUI: begin
                a_sel = A_SEL_ZERO;
            end
            OPC_AUIPC: begin
                a_sel = A_SEL_PC;
            end
            OPC_JAL, OPC_JALR: begin
                // ALU produces the link value pc+4.
                a_sel = A_SEL_PC;
                b_sel = B_SEL_FOUR;
            end
            default: begin
                illegal = 1'b1;
                a_sel   = A_SEL_ZERO;
                b_sel   = B_SEL_ZERO;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_alu_issue
// Purpose  : ID/EX pipeline stage feeding the ALU. Single-entry valid/ready
//            register holding one decoded instruction, with WB write-through
//            on accept, WB hold-capture while stalled, and combinational
//            MEM/WB forwarding on the stored operands.
// Ports    : clk, rst_n (async, active low), flush_i; in_* decode side with
//            in_valid/in_ready; mem_fwd_* / wb_fwd_* forwarding sources;
//            out_valid/out_ready with a_in, b_in, ALUControl and carried
//            fields (out_rs2_data, out_rd_idx, out_pc, out_funct3,
//            out_is_branch, out_illegal).
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_alu_issue
    import rv32i_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int FWD_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rs1_idx,
    input  logic [4:0]      in_rs2_idx,
    input  logic [4:0]      in_rd_idx,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic            mem_fwd_we,
    input  logic [4:0]      mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_fwd_we,
    input  logic [4:0]      wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] a_in,
    output logic [XLEN-1:0] b_in,
    output logic [4:0]      ALUControl,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [4:0]      out_rd_idx,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_funct3,
    output logic            out_is_branch,
    output logic            out_illegal
);

    localparam logic [XLEN-1:0] C_FOUR = XLEN'(4);

    // Decoder outputs for the instruction on the input side.
    alu_op_e dec_alu;
    a_sel_e  dec_a_sel;
    b_sel_e  dec_b_sel;
    logic    dec_is_branch;
    logic    dec_illegal;

    alu_ctrl_dec u_dec (
        .opcode    (in_opcode),
        .funct3    (in_funct3),
        .funct7b5  (in_funct7b5),
        .imm_b10   (in_imm[10]),
        .alu_ctrl  (dec_alu),
        .a_sel     (dec_a_sel),
        .b_sel     (dec_b_sel),
        .is_branch (dec_is_branch),
        .illegal   (dec_illegal)
    );

    logic            valid_q,     valid_d;
    alu_op_e         alu_q,       alu_d;
    a_sel_e          a_sel_q,     a_sel_d;
    b_sel_e          b_sel_q,     b_sel_d;
    logic            is_branch_q, is_branch_d;
    logic            illegal_q,   illegal_d;
    logic [2:0]      funct3_q,    funct3_d;
    logic [4:0]      rs1_idx_q,   rs1_idx_d;
    logic [4:0]      rs2_idx_q,   rs2_idx_d;
    logic [4:0]      rd_idx_q,    rd_idx_d;
    logic [XLEN-1:0] pc_q,        pc_d;
    logic [XLEN-1:0] imm_q,       imm_d;
    logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
    logic [XLEN-1:0] rs2_data_q,  rs2_data_d;

    logic w_accept;
    logic w_hold;

    assign in_ready = !valid_q || out_ready;
    // Flush outranks accept: the instruction presented during a flush is lost.
    assign w_accept = in_valid && in_ready && !flush_i;
    assign w_hold   = valid_q && !out_ready;

    always_comb begin
        valid_d     = valid_q;
        alu_d       = alu_q;
        a_sel_d     = a_sel_q;
        b_sel_d     = b_sel_q;
        is_branch_d = is_branch_q;
        illegal_d   = illegal_q;
        funct3_d    = funct3_q;
        rs1_idx_d   = rs1_idx_q;
        rs2_idx_d   = rs2_idx_q;
        rd_idx_d    = rd_idx_q;
        pc_d        = pc_q;
        imm_d       = imm_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;

        if (flush_i)        valid_d = 1'b0;
        else if (w_accept)  valid_d = 1'b1;
        else if (out_ready) valid_d = 1'b0;

        if (w_accept) begin
            alu_d       = dec_alu;
            a_sel_d     = dec_a_sel;
            b_sel_d     = dec_b_sel;
            is_branch_d = dec_is_branch;
            illegal_d   = dec_illegal;
            funct3_d    = in_funct3;
            rs1_idx_d   = in_rs1_idx;
            rs2_idx_d   = in_rs2_idx;
            rd_idx_d    = in_rd_idx;
            pc_d        = in_pc;
            imm_d       = in_imm;
            // The register file read misses a same-cycle WB write; take it here.
            rs1_data_d  = (wb_fwd_we && (wb_fwd_rd == in_rs1_idx) && (in_rs1_idx != 5'd0))
                          ? wb_fwd_data : in_rs1_data;
            rs2_data_d  = (wb_fwd_we && (wb_fwd_rd == in_rs2_idx) && (in_rs2_idx != 5'd0))
                          ? wb_fwd_data : in_rs2_data;
        end else if (w_hold) begin
            // A stalled instruction would lose a WB result once it retires.
            if (wb_fwd_we && (wb_fwd_rd == rs1_idx_q) && (rs1_idx_q != 5'd0))
                rs1_data_d = wb_fwd_data;
            if (wb_fwd_we && (wb_fwd_rd == rs2_idx_q) && (rs2_idx_q != 5'd0))
                rs2_data_d = wb_fwd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            alu_q       <= ALU_ADD;
            a_sel_q     <= A_SEL_RS1;
            b_sel_q     <= B_SEL_RS2;
            is_branch_q <= 1'b0;
            illegal_q   <= 1'b0;
            funct3_q    <= 3'd0;
            rs1_idx_q   <= 5'd0;
            rs2_idx_q   <= 5'd0;
            rd_idx_q    <= 5'd0;
            pc_q        <= '0;
            imm_q       <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            alu_q       <= alu_d;
            a_sel_q     <= a_sel_d;
            b_sel_q     <= b_sel_d;
            is_branch_q <= is_branch_d;
            illegal_q   <= illegal_d;
            funct3_q    <= funct3_d;
            rs1_idx_q   <= rs1_idx_d;
            rs2_idx_q   <= rs2_idx_d;
            rd_idx_q    <= rd_idx_d;
            pc_q        <= pc_d;
            imm_q       <= imm_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
        end
    end

    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    if (FWD_EN != 0) begin : g_fwd
        fwd_sel_e sel1;
        fwd_sel_e sel2;
        always_comb begin
            sel1 = fwd_select(rs1_idx_q, mem_fwd_we, mem_fwd_rd, wb_fwd_we, wb_fwd_rd);
            sel2 = fwd_select(rs2_idx_q, mem_fwd_we, mem_fwd_rd, wb_fwd_we, wb_fwd_rd);
            case (sel1)
                FWD_ZERO: rs1_fwd = '0;
                FWD_MEM:  rs1_fwd = mem_fwd_data;
                FWD_WB:   rs1_fwd = wb_fwd_data;
                default:  rs1_fwd = rs1_data_q;
            endcase
            case (sel2)
                FWD_ZERO: rs2_fwd = '0;
                FWD_MEM:  rs2_fwd = mem_fwd_data;
                FWD_WB:   rs2_fwd = wb_fwd_data;
                default:  rs2_fwd = rs2_data_q;
            endcase
        end
    end else begin : g_no_fwd
        assign rs1_fwd = rs1_data_q;
        assign rs2_fwd = rs2_data_q;
    end

    always_comb begin
        case (a_sel_q)
            A_SEL_RS1: a_in = rs1_fwd;
            A_SEL_PC:  a_in = pc_q;
            default:   a_in = '0;
        endcase
        case (b_sel_q)
            B_SEL_RS2:  b_in = rs2_fwd;
            B_SEL_IMM:  b_in = imm_q;
            B_SEL_FOUR: b_in = C_FOUR;
            default:    b_in = '0;
        endcase
    end

    assign out_valid     = valid_q;
    assign ALUControl    = alu_q;
    assign out_rs2_data  = rs2_fwd;
    assign out_rd_idx    = rd_idx_q;
    assign out_pc        = pc_q;
    assign out_funct3    = funct3_q;
    assign out_is_branch = is_branch_q;
    assign out_illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_alu_issue
// Purpose  : Self-checking bench for id_ex_alu_issue: decode table, directed
//            forwarding/stall/flush/reset sequences, and a randomized run
//            against an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [31:0] in_pc, in_imm;
    logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd_idx;
    logic [31:0] in_rs1_data, in_rs2_data;
    logic        mem_fwd_we;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_data;
    logic        wb_fwd_we;
    logic [4:0]  wb_fwd_rd;
    logic [31:0] wb_fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a_in, b_in;
    logic [4:0]  ALUControl;
    logic [31:0] out_rs2_data;
    logic [4:0]  out_rd_idx;
    logic [31:0] out_pc;
    logic [2:0]  out_funct3;
    logic        out_is_branch;
    logic        out_illegal;

    always #5 clk = ~clk;

    id_ex_alu_issue #(.XLEN(32), .FWD_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_pc(in_pc), .in_imm(in_imm),
        .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd_idx(in_rd_idx),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_in(a_in), .b_in(b_in), .ALUControl(ALUControl),
        .out_rs2_data(out_rs2_data), .out_rd_idx(out_rd_idx), .out_pc(out_pc),
        .out_funct3(out_funct3), .out_is_branch(out_is_branch), .out_illegal(out_illegal)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic [31:0] imm, input logic [31:0] pc,
                             input logic [4:0] r1, input logic [31:0] d1,
                             input logic [4:0] r2, input logic [31:0] d2,
                             input logic [4:0] rd);
        in_opcode = op;  in_funct3 = f3; in_funct7b5 = f7;
        in_imm = imm;    in_pc = pc;
        in_rs1_idx = r1; in_rs1_data = d1;
        in_rs2_idx = r2; in_rs2_data = d2;
        in_rd_idx = rd;
    endtask

    task automatic clr_fwd();
        mem_fwd_we = 1'b0; mem_fwd_rd = 5'd0; mem_fwd_data = 32'd0;
        wb_fwd_we  = 1'b0; wb_fwd_rd  = 5'd0; wb_fwd_data  = 32'd0;
    endtask

    // ---------------- reference model (instruction level) ----------------
    function automatic logic [4:0] ref_alu(input logic [6:0] op, input logic [2:0] f3,
                                           input logic f7, input logic [31:0] imm);
        logic alt;
        ref_alu = 5'b00000;
        if (op == 7'b0110011 || op == 7'b0010011) begin
            alt = (op == 7'b0110011) ? f7 : (f3 == 3'd5 ? imm[10] : 1'b0);
            case (f3)
                3'd0: ref_alu = alt ? 5'b10000 : 5'b00000;
                3'd1: ref_alu = 5'b00110;
                3'd2: ref_alu = 5'b00101;
                3'd3: ref_alu = 5'b01001;
                3'd4: ref_alu = 5'b00100;
                3'd5: ref_alu = alt ? 5'b01000 : 5'b00111;
                3'd6: ref_alu = 5'b00011;
                default: ref_alu = 5'b00010;
            endcase
        end else if (op == 7'b1100011) begin
            if (f3 == 3'd4 || f3 == 3'd5)      ref_alu = 5'b00101;
            else if (f3 == 3'd6 || f3 == 3'd7) ref_alu = 5'b01001;
            else                               ref_alu = 5'b10000;
        end
    endfunction

    function automatic logic ref_ill(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111: ref_ill = 1'b0;
            default: ref_ill = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_a(input logic [6:0] op, input logic [31:0] pc,
                                          input logic [31:0] rs1);
        case (op)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011: ref_a = rs1;
            7'b0010111, 7'b1101111, 7'b1100111:                         ref_a = pc;
            default:                                                    ref_a = 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_b(input logic [6:0] op, input logic [31:0] imm,
                                          input logic [31:0] rs2);
        case (op)
            7'b0110011, 7'b1100011:                                     ref_b = rs2;
            7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111, 7'b0010111: ref_b = imm;
            7'b1101111, 7'b1100111:                                     ref_b = 32'd4;
            default:                                                    ref_b = 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] stored);
        if (idx == 5'd0)                          ref_fwd = 32'd0;
        else if (mem_fwd_we && mem_fwd_rd == idx) ref_fwd = mem_fwd_data;
        else if (wb_fwd_we && wb_fwd_rd == idx)   ref_fwd = wb_fwd_data;
        else                                      ref_fwd = stored;
    endfunction

    logic        m_valid;
    logic [6:0]  m_op;
    logic [2:0]  m_f3;
    logic        m_f7;
    logic [31:0] m_pc, m_imm, m_rs1v, m_rs2v;
    logic [4:0]  m_rs1i, m_rs2i, m_rd;

    task automatic model_check();
        logic [31:0] r1, r2;
        chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
        chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            r1 = ref_fwd(m_rs1i, m_rs1v);
            r2 = ref_fwd(m_rs2i, m_rs2v);
            chk("rnd_alu", {27'd0, ALUControl}, {27'd0, ref_alu(m_op, m_f3, m_f7, m_imm)});
            chk("rnd_a", a_in, ref_a(m_op, m_pc, r1));
            chk("rnd_b", b_in, ref_b(m_op, m_imm, r2));
            chk("rnd_rs2", out_rs2_data, r2);
            chk("rnd_ill", {31'd0, out_illegal}, {31'd0, ref_ill(m_op)});
            chk("rnd_br", {31'd0, out_is_branch}, {31'd0, (m_op == 7'b1100011)});
            chk("rnd_rd", {27'd0, out_rd_idx}, {27'd0, m_rd});
            chk("rnd_pc", out_pc, m_pc);
        end
    endtask

    task automatic model_edge();
        logic acc, hold;
        acc  = in_valid && (!m_valid || out_ready) && !flush_i;
        hold = m_valid && !out_ready;
        if (acc) begin
            m_op = in_opcode; m_f3 = in_funct3; m_f7 = in_funct7b5;
            m_pc = in_pc; m_imm = in_imm; m_rd = in_rd_idx;
            m_rs1i = in_rs1_idx; m_rs2i = in_rs2_idx;
            m_rs1v = (wb_fwd_we && wb_fwd_rd == in_rs1_idx && in_rs1_idx != 0) ? wb_fwd_data : in_rs1_data;
            m_rs2v = (wb_fwd_we && wb_fwd_rd == in_rs2_idx && in_rs2_idx != 0) ? wb_fwd_data : in_rs2_data;
        end else if (hold) begin
            if (wb_fwd_we && wb_fwd_rd == m_rs1i && m_rs1i != 0) m_rs1v = wb_fwd_data;
            if (wb_fwd_we && wb_fwd_rd == m_rs2i && m_rs2i != 0) m_rs2v = wb_fwd_data;
        end
        if (flush_i)        m_valid = 1'b0;
        else if (acc)       m_valid = 1'b1;
        else if (out_ready) m_valid = 1'b0;
    endtask

    // ---------------- decode table ----------------
    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] imm;
        logic [4:0]  e_alu;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic        e_ill;
        logic        e_br;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [6:0] ops [10];

        rst_n = 1'b0; flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_instr(7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0);
        clr_fwd();

        // rs1=5, rs2=7, pc=0x100 throughout the table
        tbl.push_back('{7'b0110011, 3'd0, 1'b0, 32'h0,        5'b00000, 32'd5,     32'd7,        1'b0, 1'b0});
        tbl.push_back('{7'b0110011, 3'd0, 1'b1, 32'h0,        5'b10000, 32'd5,     32'd7,        1'b0, 1'b0});
        tbl.push_back('{7'b0110011, 3'd1, 1'b0, 32'h0,        5'b00110, 32'd5,     32'd7,        1'b0, 1'b0});
        tbl.push_back('{7'b0110011, 3'd2, 1'b0, 32'h0,        5'b00101, 32'd5,     32'd7,        1'b0, 1'b0});
        tbl.push_back('{7'b0110011, 3'd3, 1'b0, 32'h0,        5'b01001, 32'd5,     32'd7,        1'b0, 1'b0});
        tbl.push_back('{7'b0110011, 3'd4, 1'b0, 32'h0,        5'b00100, 32'd5,     32'd7,        1'b0, 1'b0});
        tbl.push_back('{7'b0110011, 3'd5, 1'b0, 32'h0,        5'b00111, 32'd5,     32'd7,        1'b0, 1'b0});
        tbl.push_back('{7'b0110011, 3'd5, 1'b1, 32'h0,        5'b01000, 32'd5,     32'd7,        1'b0, 1'b0});
        tbl.push_back('{7'b0110011, 3'd6, 1'b0, 32'h0,        5'b00011, 32'd5,     32'd7,        1'b0, 1'b0});
        tbl.push_back('{7'b0110011, 3'd7, 1'b0, 32'h0,        5'b00010, 32'd5,     32'd7,        1'b0, 1'b0});
        tbl.push_back('{7'b0010011, 3'd0, 1'b1, 32'hFFFFFFF0, 5'b00000, 32'd5,     32'hFFFFFFF0, 1'b0, 1'b0});
        tbl.push_back('{7'b0010011, 3'd5, 1'b0, 32'h403,      5'b01000, 32'd5,     32'h403,      1'b0, 1'b0});
        tbl.push_back('{7'b0010011, 3'd5, 1'b1, 32'h003,      5'b00111, 32'd5,     32'h3,        1'b0, 1'b0});
        tbl.push_back('{7'b0010011, 3'd3, 1'b0, 32'h001,      5'b01001, 32'd5,     32'h1,        1'b0, 1'b0});
        tbl.push_back('{7'b0000011, 3'd2, 1'b0, 32'h8,        5'b00000, 32'd5,     32'h8,        1'b0, 1'b0});
        tbl.push_back('{7'b0100011, 3'd2, 1'b0, 32'hFFFFFFFC, 5'b00000, 32'd5,     32'hFFFFFFFC, 1'b0, 1'b0});
        tbl.push_back('{7'b1100011, 3'd0, 1'b0, 32'h10,       5'b10000, 32'd5,     32'd7,        1'b0, 1'b1});
        tbl.push_back('{7'b1100011, 3'd1, 1'b0, 32'h10,       5'b10000, 32'd5,     32'd7,        1'b0, 1'b1});
        tbl.push_back('{7'b1100011, 3'd4, 1'b0, 32'h10,       5'b00101, 32'd5,     32'd7,        1'b0, 1'b1});
        tbl.push_back('{7'b1100011, 3'd6, 1'b0, 32'h10,       5'b01001, 32'd5,     32'd7,        1'b0, 1'b1});
        tbl.push_back('{7'b1100011, 3'd7, 1'b0, 32'h10,       5'b01001, 32'd5,     32'd7,        1'b0, 1'b1});
        tbl.push_back('{7'b0110111, 3'd0, 1'b0, 32'h12345000, 5'b00000, 32'd0,     32'h12345000, 1'b0, 1'b0});
        tbl.push_back('{7'b0010111, 3'd0, 1'b0, 32'h1000,     5'b00000, 32'h100,   32'h1000,     1'b0, 1'b0});
        tbl.push_back('{7'b1101111, 3'd0, 1'b0, 32'h20,       5'b00000, 32'h100,   32'd4,        1'b0, 1'b0});
        tbl.push_back('{7'b1100111, 3'd0, 1'b0, 32'h8,        5'b00000, 32'h100,   32'd4,        1'b0, 1'b0});
        tbl.push_back('{7'b0001111, 3'd0, 1'b0, 32'h0,        5'b00000, 32'd0,     32'd0,        1'b1, 1'b0});
        tbl.push_back('{7'b0000000, 3'd0, 1'b0, 32'h5,        5'b00000, 32'd0,     32'd0,        1'b1, 1'b0});

        // ---- reset state ----
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_a_in", a_in, 32'd0);
        chk("rst_b_in", b_in, 32'd0);
        chk("rst_alu", {27'd0, ALUControl}, 32'd0);
        chk("rst_illegal", {31'd0, out_illegal}, 32'd0);
        rst_n = 1'b1;
        tick();

        // ---- decode table ----
        out_ready = 1'b1;
        foreach (tbl[i]) begin
            set_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].imm, 32'h100,
                      5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("tbl%0d_alu", i), {27'd0, ALUControl}, {27'd0, tbl[i].e_alu});
            chk($sformatf("tbl%0d_a", i), a_in, tbl[i].e_a);
            chk($sformatf("tbl%0d_b", i), b_in, tbl[i].e_b);
            chk($sformatf("tbl%0d_ill", i), {31'd0, out_illegal}, {31'd0, tbl[i].e_ill});
            chk($sformatf("tbl%0d_br", i), {31'd0, out_is_branch}, {31'd0, tbl[i].e_br});
            chk($sformatf("tbl%0d_f3", i), {29'd0, out_funct3}, {29'd0, tbl[i].f3});
            chk($sformatf("tbl%0d_rd", i), {27'd0, out_rd_idx}, 32'd3);
        end
        tick();
        chk("tbl_drain", {31'd0, out_valid}, 32'd0);

        // ---- forwarding priority on a held instruction ----
        set_instr(7'b0110011, 3'd0, 1'b0, 32'd0, 32'h200, 5'd1, 32'h11, 5'd2, 32'h22, 5'd3);
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd1; mem_fwd_data = 32'hAA;
        wb_fwd_we  = 1'b1; wb_fwd_rd  = 5'd1; wb_fwd_data  = 32'hBB;
        #1 chk("fwd_mem_over_wb", a_in, 32'hAA);
        mem_fwd_we = 1'b0;
        #1 chk("fwd_wb_only", a_in, 32'hBB);
        wb_fwd_we = 1'b0;
        #1 chk("fwd_stored", a_in, 32'h11);
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd2; mem_fwd_data = 32'hCC;
        #1 chk("fwd_mem_b", b_in, 32'hCC);
        chk("fwd_mem_rs2out", out_rs2_data, 32'hCC);
        clr_fwd();
        // x0 source with stale nonzero read data and a MEM write to x0
        set_instr(7'b0110011, 3'd0, 1'b0, 32'd0, 32'h204, 5'd0, 32'h99, 5'd2, 32'h22, 5'd3);
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hAA;
        #1 chk("fwd_x0", a_in, 32'd0);
        clr_fwd();
        // write-through of a same-cycle WB write on accept
        set_instr(7'b0110011, 3'd0, 1'b0, 32'd0, 32'h208, 5'd1, 32'h11, 5'd2, 32'h22, 5'd3);
        wb_fwd_we = 1'b1; wb_fwd_rd = 5'd1; wb_fwd_data = 32'h77;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; clr_fwd();
        chk("wt_rs1", a_in, 32'h77);
        chk("wt_rs2_untouched", b_in, 32'h22);
        tick();

        // ---- stall with hold capture, then release ----
        set_instr(7'b0110011, 3'd0, 1'b0, 32'd0, 32'h300, 5'd1, 32'h10, 5'd2, 32'h22, 5'd3);
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        set_instr(7'b0110011, 3'd0, 1'b1, 32'd0, 32'h304, 5'd1, 32'h30, 5'd2, 32'h40, 5'd4);
        #3 chk("stall1_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall1_b", b_in, 32'h22);
        tick();
        wb_fwd_we = 1'b1; wb_fwd_rd = 5'd2; wb_fwd_data = 32'h55;
        #3 chk("stall2_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall2_b_fwd", b_in, 32'h55);
        tick();
        clr_fwd();
        #3 chk("stall3_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall3_b_captured", b_in, 32'h55);
        chk("stall3_valid", {31'd0, out_valid}, 32'd1);
        tick();
        out_ready = 1'b1;
        #3 chk("release_b", b_in, 32'h55);
        chk("release_alu", {27'd0, ALUControl}, 32'd0);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("next_valid", {31'd0, out_valid}, 32'd1);
        chk("next_alu", {27'd0, ALUControl}, 32'b10000);
        chk("next_a", a_in, 32'h30);
        chk("next_b", b_in, 32'h40);
        chk("next_rd", {27'd0, out_rd_idx}, 32'd4);
        tick();
        chk("no_dup", {31'd0, out_valid}, 32'd0);

        // ---- flush while full, new instruction dropped ----
        set_instr(7'b0110011, 3'd0, 1'b0, 32'd0, 32'h400, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3);
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        set_instr(7'b0110011, 3'd7, 1'b0, 32'd0, 32'h404, 5'd1, 32'h3, 5'd2, 32'h4, 5'd5);
        flush_i = 1'b1;
        #3 chk("flush_pre_valid", {31'd0, out_valid}, 32'd1);
        tick();
        flush_i = 1'b0; in_valid = 1'b0;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("flush_dropped", {31'd0, out_valid}, 32'd0);

        // ---- back-to-back stream ----
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_instr(7'b0110011, 3'd0, 1'b0, 32'd0, 32'h500, 5'd1, 32'(k + 1), 5'd2, 32'h2, 5'd3);
            in_valid = 1'b1;
            tick();
            chk($sformatf("b2b%0d_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("b2b%0d_a", k), a_in, 32'(k + 1));
        end
        in_valid = 1'b0;
        tick();

        // ---- async reset in the middle of a stall ----
        set_instr(7'b0110011, 3'd0, 1'b1, 32'd0, 32'h600, 5'd1, 32'h9, 5'd2, 32'h8, 5'd3);
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_alu", {27'd0, ALUControl}, 32'd0);
        chk("arst_a", a_in, 32'd0);
        chk("arst_b", b_in, 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("arst_after", {31'd0, out_valid}, 32'd0);

        // ---- randomized run against the model ----
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
        ops[4] = 7'b1100011; ops[5] = 7'b0110111; ops[6] = 7'b0010111; ops[7] = 7'b1101111;
        ops[8] = 7'b1100111; ops[9] = 7'b0001111;
        m_valid = 1'b0;
        m_op = '0; m_f3 = '0; m_f7 = 1'b0; m_pc = '0; m_imm = '0;
        m_rs1v = '0; m_rs2v = '0; m_rs1i = '0; m_rs2i = '0; m_rd = '0;
        for (int c = 0; c < 400; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            flush_i     = ($urandom_range(0, 15) == 0);
            set_instr(ops[$urandom_range(0, 9)], 3'($urandom), 1'($urandom), $urandom,
                      $urandom, 5'($urandom_range(0, 3)), $urandom,
                      5'($urandom_range(0, 3)), $urandom, 5'($urandom));
            mem_fwd_we   = 1'($urandom);
            mem_fwd_rd   = 5'($urandom_range(0, 3));
            mem_fwd_data = $urandom;
            wb_fwd_we    = 1'($urandom);
            wb_fwd_rd    = 5'($urandom_range(0, 3));
            wb_fwd_data  = $urandom;
            #3 model_check();
            model_edge();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
